// File: rtl/fir_tdm_mc.sv
// fir_tdm_mc: multi-channel time-multiplexed FIR sharing one MAC across N_CH round-robin channels.
// Define FIR_SATURATE_EN to clamp out-of-range outputs; otherwise the integer MSBs wrap.
module fir_tdm_mc #(
  parameter int N_TAPS      = 15,
  parameter int N_CH        = 2,
  parameter int COE_INTE_WL = 4,
  parameter int COE_FRAC_WL = 8,
  parameter int IN_INTE_WL  = 4,
  parameter int IN_FRAC_WL  = 8,
  parameter int OUT_INTE_WL = 4,
  parameter int OUT_FRAC_WL = 8,
  parameter int PRODUCT_FRAC_WL_ARRAY [0:N_TAPS-1] = '{default: 12}
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic signed [IN_INTE_WL+IN_FRAC_WL-1:0]         data_in,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  output logic        [OUT_INTE_WL+OUT_FRAC_WL-1:0]       data_out,
  output logic        [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] out_ch,
  output logic                                            out_valid,
  input  logic                                            coe_we,
  input  logic [(N_TAPS > 1 ? $clog2(N_TAPS) : 1)-1:0]    coe_addr,
  input  logic signed [COE_INTE_WL+COE_FRAC_WL-1:0]       coe_data
);
  localparam int IN_W  = IN_INTE_WL + IN_FRAC_WL;
  localparam int COE_W = COE_INTE_WL + COE_FRAC_WL;
  localparam int OUT_W = OUT_INTE_WL + OUT_FRAC_WL;
  localparam int FF    = COE_FRAC_WL + IN_FRAC_WL;
  localparam int P_W   = IN_W + COE_W;
  localparam int ACC_W = COE_INTE_WL + IN_INTE_WL + $clog2(N_TAPS) + FF;
  localparam int SH    = FF - OUT_FRAC_WL;
  localparam int CH_W  = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int K_W   = N_TAPS > 1 ? $clog2(N_TAPS) : 1;
  localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'((2**SH) / 2);
  localparam logic signed [ACC_W:0] O_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] O_MIN = -(ACC_W+1)'(2**(OUT_W-1));
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
  state_t                  r_state;
  logic signed [IN_W-1:0]  r_dline [N_CH][N_TAPS];
  logic signed [COE_W-1:0] r_coef [N_TAPS];
  logic [CH_W-1:0]         r_ch;
  logic [K_W-1:0]          r_k;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_data_out;
  logic [CH_W-1:0]         r_out_ch;
  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W:0]   w_rnd;
  logic [OUT_W-1:0]        w_res;
  logic                    w_coe_wr;
  assign in_ready  = r_state == S_IDLE;
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign out_ch    = r_out_ch;
  assign w_coe_wr  = in_ready && coe_we && int'(coe_addr) < N_TAPS;
  assign w_prod    = r_coef[r_k] * r_dline[r_ch][r_k];
  // floor the product by clearing the fractional LSBs this tap does not keep
  assign w_term     = ACC_W'(w_prod) & ({ACC_W{1'b1}} << (FF - PRODUCT_FRAC_WL_ARRAY[r_k]));
  assign w_acc_next = r_acc + w_term;
  assign w_rnd      = ((ACC_W+1)'(w_acc_next) + RND) >>> SH;
`ifdef FIR_SATURATE_EN
  assign w_res = w_rnd > O_MAX ? OUT_W'(O_MAX) : w_rnd < O_MIN ? OUT_W'(O_MIN) : w_rnd[OUT_W-1:0];
`else
  assign w_res = w_rnd[OUT_W-1:0];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_out_ch    <= '0;
      for (int c = 0; c < N_CH; c++)
        for (int t = 0; t < N_TAPS; t++) r_dline[c][t] <= '0;
      for (int t = 0; t < N_TAPS; t++) r_coef[t] <= '0;
    end else begin
      if (w_coe_wr) r_coef[coe_addr] <= coe_data;
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_dline[r_ch][0] <= data_in;
          for (int t = 1; t < N_TAPS; t++) r_dline[r_ch][t] <= r_dline[r_ch][t-1];
          r_acc   <= '0;
          r_k     <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 1'b1;
          // the last product is folded in combinationally so the result is ready on entry to OUT
          if (r_k == K_W'(N_TAPS - 1)) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
            r_data_out  <= w_res;
            r_out_ch    <= r_ch;
          end
        end
        default: begin
          r_ch    <= r_ch == CH_W'(N_CH - 1) ? '0 : r_ch + 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tdm_mc.sv
// tb_fir_tdm_mc: scoreboard bench for fir_tdm_mc against an arithmetic reference model.
module tb_fir_tdm_mc;
  localparam int NT = 4, NC = 2, FF = 16, SH = 8;
  localparam int PFW [0:NT-1] = '{8, 12, 12, 12};
  logic        clk = 0, rst = 1;
  logic [11:0] data_in = '0;
  logic        in_valid = 0, in_ready, out_valid;
  logic [11:0] data_out;
  logic [0:0]  out_ch;
  logic        coe_we = 0;
  logic [1:0]  coe_addr = '0;
  logic [11:0] coe_data = '0;
  fir_tdm_mc #(.N_TAPS(NT), .N_CH(NC), .PRODUCT_FRAC_WL_ARRAY(PFW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_ch(out_ch), .out_valid(out_valid),
    .coe_we(coe_we), .coe_addr(coe_addr), .coe_data(coe_data));
  always #5 clk = ~clk;
  typedef struct {int ch; longint val; longint due;} exp_t;
  exp_t   sb[$];
  exp_t   got[$];
  int     hist [NC][NT];
  int     coef [NT];
  int     m_ch = 0, m_busy = 0, n_chk = 0, n_fail = 0;
  longint cyc = 0;
  bit     mon_en = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not match expectation (cycle %0d)", nm, cyc);
  endtask
  function automatic longint fdiv(input longint a, input longint b);
    return a >= 0 ? a / b : -((-a + b - 1) / b);
  endfunction
  // filter output from the current history and coefficients, as a 12-bit pattern
  function automatic longint ref_out(input int ch);
    longint acc = 0, r, step;
    for (int k = 0; k < NT; k++) begin
      step = longint'(2) ** (FF - PFW[k]);
      acc += fdiv(longint'(coef[k]) * hist[ch][k], step) * step;
    end
    r = fdiv(acc + 2 ** (SH - 1), 2 ** SH);
`ifdef FIR_SATURATE_EN
    r = r > 2047 ? 2047 : r < -2048 ? -2048 : r;
`endif
    return r & 'hFFF;
  endfunction
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      hist = '{default: 0};
      coef = '{default: 0};
      m_ch = 0;
      m_busy = 0;
      sb.delete();
    end else if (m_busy == 0) begin
      if (coe_we) coef[coe_addr] = int'($signed(coe_data));
      if (in_valid) begin
        for (int k = NT - 1; k > 0; k--) hist[m_ch][k] = hist[m_ch][k-1];
        hist[m_ch][0] = int'($signed(data_in));
        sb.push_back('{m_ch, ref_out(m_ch), cyc + NT});
        m_ch = (m_ch + 1) % NC;
        m_busy = NT + 1;
      end
    end else m_busy--;
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en) begin
      chk("in_ready", in_ready, m_busy == 0);
      if (sb.size() > 0 && sb[0].due < cyc) begin
        fail_now("missing_out");
        void'(sb.pop_front());
      end
      if (out_valid) begin
        got.push_back('{int'(out_ch), longint'(data_out), cyc});
        if (sb.size() == 0) fail_now("unexpected_out");
        else begin
          e = sb.pop_front();
          chk("data_out", data_out, e.val);
          chk("out_ch", out_ch, e.ch);
          chk("latency", cyc, e.due);
        end
      end
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) fail_now("ready_timeout");
  endtask
  task automatic send(input int d, input bit we = 0, input int a = 0, input int c = 0);
    wait_ready();
    in_valid = 1; data_in = 12'(d);
    coe_we = we; coe_addr = 2'(a); coe_data = 12'(c);
    tick();
    in_valid = 0; coe_we = 0;
  endtask
  task automatic wr_coef(input int a, input int c);
    wait_ready();
    coe_we = 1; coe_addr = 2'(a); coe_data = 12'(c);
    tick();
    coe_we = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() > 0 || m_busy != 0) && n < 200) begin tick(); n++; end
    if (n >= 200) fail_now("drain_timeout");
    tick(); tick();
  endtask
  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask
  initial begin
    int imp [5] = '{256, 128, 64, 32, 0};
    tick(); tick(); tick();
    rst = 0;
    mon_en = 1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ch", out_ch, 0);
    // impulse on ch0, silence on ch1
    wr_coef(0, 256); wr_coef(1, 128); wr_coef(2, 64); wr_coef(3, 32);
    got.delete();
    for (int i = 0; i < 10; i++) send(i == 0 ? 256 : 0);
    drain();
    chk("imp_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      chk("imp_ch", got[i].ch, i % 2);
      chk("imp_val", got[i].val, i % 2 ? 0 : imp[i / 2]);
    end
    // continuous in_valid: only accepted samples produce outputs
    for (int i = 0; i < 60; i++) begin
      in_valid = 1; data_in = 12'((i % 10) + 1); tick();
    end
    in_valid = 0;
    drain();
    // rounding and per-tap truncation
    do_reset();
    wr_coef(1, 128);
    got.delete();
    send(1); send(0); send(0); send(0); send(-1); send(0); send(0); send(0);
    wr_coef(0, 128); wr_coef(1, 0);
    send(1);
    drain();
    chk("rnd_count", got.size(), 9);
    if (got.size() == 9) begin
      chk("rnd_pos_half", got[2].val, 1);
      chk("rnd_neg_half", got[6].val, 0);
      chk("trunc_frac8", got[8].val, 0);
    end
    // overflow
    do_reset();
    for (int k = 0; k < NT; k++) wr_coef(k, 2047);
    got.delete();
    for (int i = 0; i < 8; i++) send(2047);
    drain();
    chk("ovf_count", got.size(), 8);
    if (got.size() == 8) begin
`ifdef FIR_SATURATE_EN
      chk("ovf_ch0", got[6].val, 'h7FF);
      chk("ovf_ch1", got[7].val, 'h7FF);
`else
      chk("ovf_ch0", got[6].val, 'hFC0);
      chk("ovf_ch1", got[7].val, 'hFC0);
`endif
    end
    // coefficient write gating
    do_reset();
    wr_coef(0, 256);
    got.delete();
    send(100);
    coe_we = 1; coe_addr = 0; coe_data = 12'd512; tick(); coe_we = 0;
    drain();
    send(100);
    send(100, 1, 0, 512);
    drain();
    chk("gate_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("gate_busy_write", got[0].val, 100);
      chk("gate_later", got[1].val, 100);
      chk("gate_idle_write", got[2].val, 200);
    end
    // reset in the middle of MAC
    do_reset();
    wr_coef(0, 256);
    got.delete();
    send(50);
    tick();
    rst = 1; tick(); rst = 0;
    chk("ready_after_rst", in_ready, 1);
    send(256);
    drain();
    chk("midrst_count", got.size(), 1);
    if (got.size() == 1) begin
      chk("midrst_val", got[0].val, 0);
      chk("midrst_ch", got[0].ch, 0);
    end
    // random traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      in_valid = $urandom_range(2) == 0;
      data_in = 12'($urandom);
      coe_we = $urandom_range(3) == 0;
      coe_addr = 2'($urandom);
      coe_data = 12'($urandom);
      tick();
    end
    in_valid = 0; coe_we = 0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir_tdm_mc.md
Name: fir_tdm_mc

Overview:
Multi-channel, time-multiplexed fixed-point FIR filter and the parametrised successor of the single-channel FIR. One shared multiplier-accumulator serves N_CH interleaved channels, each with its own N_TAPS delay line. Coefficients are run-time loadable and shared by all channels; the per-tap product truncation widths are kept from the existing wordlength-optimisation flow. Sits between the fixed-point sample source and the output writer, using the same in_valid/out_valid style.

Parameters:
N_TAPS, 15, filter length; taps indexed 0..N_TAPS-1.
N_CH, 2, number of interleaved channels (>=1).
COE_INTE_WL, 4, coefficient integer bits, sign included.
COE_FRAC_WL, 8, coefficient fractional bits.
IN_INTE_WL, 4, input integer bits, sign included.
IN_FRAC_WL, 8, input fractional bits.
OUT_INTE_WL, 4, output integer bits, sign included.
OUT_FRAC_WL, 8, output fractional bits (must be <= COE_FRAC_WL+IN_FRAC_WL).
PRODUCT_FRAC_WL_ARRAY, all 12, per-tap int array [0:N_TAPS-1]; fractional bits kept of product k.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
data_in  in  IN_INTE_WL+IN_FRAC_WL  signed input sample.
in_valid  in  1  data_in valid.
in_ready  out  1  block can accept a sample this cycle.
data_out  out  OUT_INTE_WL+OUT_FRAC_WL  signed filtered sample.
out_ch  out  clog2(N_CH) (min 1)  channel of data_out.
out_valid  out  1  one-cycle pulse, data_out/out_ch valid.
coe_we  in  1  coefficient write strobe.
coe_addr  in  clog2(N_TAPS)  tap index to write.
coe_data  in  COE_INTE_WL+COE_FRAC_WL  signed coefficient.

Behaviour:
- Reset (sync, high): state IDLE; all delay lines and coefficients 0; channel pointer 0; accumulator 0; in_ready=1 on the first cycle after reset; out_valid=0, data_out=0, out_ch=0.
- Reset mid-operation: any in-flight computation is discarded; no out_valid pulse is produced for it.
- FSM IDLE: in_ready=1.
  - On in_valid=1, the sample is accepted. It is shifted into the delay line of channel ch_ptr (tap0 = newest; the oldest sample is dropped), the accumulator is cleared, k=0, and the FSM goes to MAC.
- FSM MAC: in_ready=0; runs N_TAPS cycles.
  - Each cycle: acc += trunc_k(coef[k] * dline[ch_ptr][k]), then k++.
  - After k=N_TAPS-1 the FSM goes to OUT.
- FSM OUT: in_ready=0.
  - The registered out_valid=1, data_out and out_ch=ch_ptr are presented for this one cycle.
  - ch_ptr wraps N_CH-1 -> 0, then the FSM goes to IDLE.
- Latency: a sample accepted at cycle t gives out_valid at cycle t+N_TAPS+1. Peak throughput is one sample per N_TAPS+2 cycles.
- Channel order: samples are strictly round-robin starting at ch0. There is no channel input.
- No output backpressure; out_valid is never held.
- in_valid while in_ready=0: the sample is ignored and not queued.
- Product arithmetic: the full product has COE_FRAC_WL+IN_FRAC_WL fractional bits. trunc_k floors it (two's-complement, toward -inf) by zeroing the fractional LSBs below PRODUCT_FRAC_WL_ARRAY[k].
- Accumulator width: COE_INTE_WL+IN_INTE_WL+clog2(N_TAPS) integer bits plus full fractional bits. It never overflows.
- Output rounding: add 2^-(OUT_FRAC_WL+1), then floor to OUT_FRAC_WL bits (round half up). Integer overflow is handled per FIR_SATURATE_EN.
- Coefficient write:
  - Honoured only in IDLE. A write and an accepted sample in the same cycle are both honoured, and the new coefficient applies to that sample.
  - coe_we outside IDLE is ignored.
  - coe_addr >= N_TAPS is ignored.

Optional Feature:
- Macro: FIR_SATURATE_EN.
- Defined: a rounded result above the output range clamps to max (0111..1); one below it clamps to min (1000..0).
- Undefined: the integer MSBs are discarded (two's-complement wrap), matching the original FIR.

Test Plan:
- Impulse, N_TAPS=4, N_CH=2, default widths, coefficients {256,128,64,32}:
  - Input interleaved ch0={256,0,0,0,0}, ch1 all 0.
  - Required: ch0 outputs 256,128,64,32,0; ch1 outputs all 0; out_ch alternates 0,1.
- Latency/handshake:
  - Hold in_valid=1 continuously with data 1..10.
  - Required: in_ready is high 1 cycle in every N_TAPS+2; only samples presented while in_ready=1 are accepted; each out_valid comes exactly N_TAPS+1 cycles after its accept.
- Rounding/truncation, coef[0]=128 (0.5), other coefficients 0, input 1 LSB:
  - PRODUCT_FRAC_WL=12 -> data_out=1.
  - Input -1 LSB -> data_out=0.
  - PRODUCT_FRAC_WL[0]=8 with +1 LSB input -> data_out=0.
- Overflow, all coefficients 2047, input 2047, N_TAPS=4:
  - FIR_SATURATE_EN defined -> data_out=2047 (0x7FF).
  - Undefined -> data_out equals the low 12 bits of the rounded sum.
- Coefficient write gating:
  - coe_we during MAC -> no effect on current or later outputs.
  - Same write in IDLE together with in_valid -> applies to that sample's output.
- Reset mid-MAC:
  - rst=1 for 1 cycle during MAC -> no out_valid for that sample; in_ready=1 next cycle; the next impulse response shows a zeroed history and zero coefficients (output 0 until coefficients are reloaded).
